// File: rtl/sram_controller.sv
// Data-memory port: runs each EXE/MEM load/store as two half-word accesses on a 16-bit async SRAM.
// Optional build macro SRAM_ADDR_CHECK_EN rejects out-of-range addresses and adds sticky addr_err.
module sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  inout  logic [15:0]        sram_dq,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
`ifdef SRAM_ADDR_CHECK_EN
  ,
  output logic               addr_err
`endif
);

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StWrLo = 3'd1;
  localparam logic [2:0] StWrHi = 3'd2;
  localparam logic [2:0] StRdLo = 3'd3;
  localparam logic [2:0] StRdHi = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [15:0]        rd_lo_q, rd_lo_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        offset;
  logic [SRAM_AW-1:0] addr_lo, addr_hi;
  logic               req, cnt_last, drive;
  logic [15:0]        dq_out;
  logic               unused_offset;

  assign sram_ce_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

  assign req      = mem_r_en | mem_w_en;
  assign cnt_last = (cnt_q == CntLast);
  assign offset   = address - BASE_ADDR;
  // Half-word addresses of the 32-bit word; upper offset bits wrap away by truncation.
  assign addr_lo  = {offset[SRAM_AW:2], 1'b0};
  assign addr_hi  = {offset[SRAM_AW:2], 1'b1};
  assign unused_offset = ^{offset[31:SRAM_AW+1], offset[1:0]};

  assign sram_dq = drive ? dq_out : 16'bz;
  assign rdata   = rdata_q;

`ifdef SRAM_ADDR_CHECK_EN
  logic addr_err_q, addr_err_d, addr_bad;
  assign addr_bad = (address < BASE_ADDR) | (|offset[31:SRAM_AW+1]);
  assign addr_err = addr_err_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_lo_d = rd_lo_q;
    rdata_d = rdata_q;
`ifdef SRAM_ADDR_CHECK_EN
    addr_err_d = addr_err_q;
`endif
    case (state_q)
      StIdle: begin
        cnt_d = '0;
`ifdef SRAM_ADDR_CHECK_EN
        if (req && addr_bad) begin
          state_d    = StDone;
          addr_err_d = 1'b1;
        end else
`endif
        if (mem_w_en) state_d = StWrLo;
        else if (mem_r_en) state_d = StRdLo;
      end
      StWrLo, StWrHi, StRdLo, StRdHi: begin
        if (cnt_last) begin
          cnt_d = '0;
          case (state_q)
            StWrLo:  state_d = StWrHi;
            StRdLo:  begin
              state_d = StRdHi;
              rd_lo_d = sram_dq;
            end
            StRdHi:  begin
              state_d = StDone;
              rdata_d = {sram_dq, rd_lo_q};
            end
            default: state_d = StDone;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    sram_addr = '0;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b1;
    drive     = 1'b0;
    dq_out    = 16'h0000;
    case (state_q)
      StIdle: ready = ~req;
      StWrLo: begin
        sram_addr = addr_lo;
        sram_we_n = 1'b0;
        drive     = 1'b1;
        dq_out    = wdata[15:0];
      end
      StWrHi: begin
        sram_addr = addr_hi;
        sram_we_n = 1'b0;
        drive     = 1'b1;
        dq_out    = wdata[31:16];
      end
      StRdLo: begin
        sram_addr = addr_lo;
        sram_oe_n = 1'b0;
      end
      StRdHi: begin
        sram_addr = addr_hi;
        sram_oe_n = 1'b0;
      end
      StDone:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rd_lo_q <= '0;
      rdata_q <= '0;
`ifdef SRAM_ADDR_CHECK_EN
      addr_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_lo_q <= rd_lo_d;
      rdata_q <= rdata_d;
`ifdef SRAM_ADDR_CHECK_EN
      addr_err_q <= addr_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (WAIT_CYCLES=2 and 1), each with an async SRAM model,
// checked against a word-level reference memory.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  r_en, w_en, rdy, we_n, oe_n, ce_n, ub_n, lb_n, aerr;
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic [17:0] sa [2];
  wire  [15:0] dq0, dq1;

  logic [15:0] mem0 [262144];
  logic [15:0] mem1 [262144];
  logic [31:0] refm [int];
  logic [31:0] last_rd [2];

  logic [17:0] snap_addr [40];
  logic        snap_we [40];
  logic        snap_oe [40];
  logic [15:0] snap_dq [40];

  int n_run, n_fail;

  always #5 clk = ~clk;

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(2), .SRAM_AW(18)) u_dut0 (
    .clk(clk), .rst(rst), .mem_r_en(r_en[0]), .mem_w_en(w_en[0]), .address(addr[0]),
    .wdata(wdat[0]), .rdata(rdat[0]), .ready(rdy[0]), .sram_dq(dq0), .sram_addr(sa[0]),
    .sram_we_n(we_n[0]), .sram_oe_n(oe_n[0]), .sram_ce_n(ce_n[0]), .sram_ub_n(ub_n[0]),
    .sram_lb_n(lb_n[0])
`ifdef SRAM_ADDR_CHECK_EN
    , .addr_err(aerr[0])
`endif
  );

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(1), .SRAM_AW(18)) u_dut1 (
    .clk(clk), .rst(rst), .mem_r_en(r_en[1]), .mem_w_en(w_en[1]), .address(addr[1]),
    .wdata(wdat[1]), .rdata(rdat[1]), .ready(rdy[1]), .sram_dq(dq1), .sram_addr(sa[1]),
    .sram_we_n(we_n[1]), .sram_oe_n(oe_n[1]), .sram_ce_n(ce_n[1]), .sram_ub_n(ub_n[1]),
    .sram_lb_n(lb_n[1])
`ifdef SRAM_ADDR_CHECK_EN
    , .addr_err(aerr[1])
`endif
  );

  // Async SRAM models: drive on oe_n, capture every cycle we_n is low.
  assign dq0 = (!oe_n[0] && we_n[0]) ? mem0[sa[0]] : 16'bz;
  assign dq1 = (!oe_n[1] && we_n[1]) ? mem1[sa[1]] : 16'bz;
  always @(posedge clk) if (!we_n[0]) mem0[sa[0]] <= dq0;
  always @(posedge clk) if (!we_n[1]) mem1[sa[1]] <= dq1;

  function automatic int widx(input int s, input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return s * (1 << 20) + int'((off >> 2) % (1 << 17));
  endfunction

  function automatic logic [31:0] ref_rd(input int s, input logic [31:0] a);
    return refm.exists(widx(s, a)) ? refm[widx(s, a)] : 32'h0;
  endfunction

  // Issue one request, record the bus each cycle, count ready-low cycles (bounded).
  task automatic run_req(input int s, input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, output int lows, output logic [31:0] rd);
    @(negedge clk);
    w_en[s] = w; r_en[s] = r; addr[s] = a; wdat[s] = d;
    lows = 0; rd = '0;
    for (int c = 0; c < 40; c++) begin
      #1;
      snap_addr[c] = sa[s]; snap_we[c] = we_n[s]; snap_oe[c] = oe_n[s];
      snap_dq[c] = (s == 1) ? dq1 : dq0;
      if (rdy[s]) begin
        rd = rdat[s];
        break;
      end
      lows++;
      @(negedge clk);
    end
    w_en[s] = 1'b0; r_en[s] = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    for (int s = 0; s < 2; s++) begin
      n_run++;
      if ({rdy[s], we_n[s], oe_n[s], sa[s], rdat[s]} !== {3'b111, 18'd0, 32'd0}) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got rdy=%b we_n=%b oe_n=%b addr=%0d rdata=%h want 1 1 1 0 0",
                 s, rdy[s], we_n[s], oe_n[s], sa[s], rdat[s]);
      end
    end
    n_run++;
    if ({ce_n, ub_n, lb_n} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_enables: got %b want 000000", {ce_n, ub_n, lb_n});
    end
`ifdef SRAM_ADDR_CHECK_EN
    n_run++;
    if (aerr !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_addr_err: got %b want 00", aerr);
    end
`endif
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store();
    int lows; logic [31:0] rd;
    run_req(0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, lows, rd);
    refm[widx(0, 1024)] = 32'hDEADBEEF;
    n_run++;
    if (lows !== 5) begin
      n_fail++; $display("FAIL store_latency: got %0d want 5", lows);
    end
    for (int c = 0; c <= 5; c++) begin
      logic [17:0] ea; logic ewe; logic [15:0] ed;
      ea  = (c == 3 || c == 4) ? 18'd1 : 18'd0;
      ewe = !(c >= 1 && c <= 4);
      ed  = (c <= 2) ? 16'hBEEF : 16'hDEAD;
      n_run++;
      if ({snap_addr[c], snap_we[c], snap_oe[c]} !== {ea, ewe, 1'b1}) begin
        n_fail++;
        $display("FAIL store_bus c%0d: got addr=%0d we_n=%b oe_n=%b want addr=%0d we_n=%b oe_n=1",
                 c, snap_addr[c], snap_we[c], snap_oe[c], ea, ewe);
      end
      if (!ewe) begin
        n_run++;
        if (snap_dq[c] !== ed) begin
          n_fail++; $display("FAIL store_dq c%0d: got %h want %h", c, snap_dq[c], ed);
        end
      end
    end
    n_run++;
    if (rd !== last_rd[0]) begin
      n_fail++; $display("FAIL store_rdata_kept: got %h want %h", rd, last_rd[0]);
    end
  endtask

  task automatic test_load();
    int lows; logic [31:0] rd;
    mem0[2] = 16'h5678; mem0[3] = 16'h1234;
    refm[widx(0, 1028)] = 32'h12345678;
    run_req(0, 1'b0, 1'b1, 32'd1028, 32'h0, lows, rd);
    n_run++;
    if (lows !== 5) begin
      n_fail++; $display("FAIL load_latency: got %0d want 5", lows);
    end
    n_run++;
    if (rd !== ref_rd(0, 1028)) begin
      n_fail++; $display("FAIL load_data: got %h want %h", rd, ref_rd(0, 1028));
    end
    last_rd[0] = ref_rd(0, 1028);
    for (int c = 0; c <= 5; c++) begin
      logic eoe; logic [17:0] ea;
      eoe = !(c >= 1 && c <= 4);
      ea  = (c == 1 || c == 2) ? 18'd2 : (c == 3 || c == 4) ? 18'd3 : 18'd0;
      n_run++;
      if ({snap_addr[c], snap_we[c], snap_oe[c]} !== {ea, 1'b1, eoe}) begin
        n_fail++;
        $display("FAIL load_bus c%0d: got addr=%0d we_n=%b oe_n=%b want addr=%0d we_n=1 oe_n=%b",
                 c, snap_addr[c], snap_we[c], snap_oe[c], ea, eoe);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lows; logic [31:0] rd;
    run_req(0, 1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, lows, rd);
    refm[widx(0, 1032)] = 32'hCAFEF00D;
    n_run++;
    if ({snap_we[5], snap_oe[5], snap_addr[5]} !== {2'b11, 18'd0}) begin
      n_fail++;
      $display("FAIL b2b_done_idle: got we_n=%b oe_n=%b addr=%0d want 1 1 0",
               snap_we[5], snap_oe[5], snap_addr[5]);
    end
    run_req(0, 1'b0, 1'b1, 32'd1032, 32'h0, lows, rd);
    n_run++;
    if (lows !== 5 || rd !== ref_rd(0, 1032)) begin
      n_fail++;
      $display("FAIL b2b_load: got lows=%0d rdata=%h want 5 %h", lows, rd, ref_rd(0, 1032));
    end
    last_rd[0] = ref_rd(0, 1032);
    @(negedge clk); #1;
    n_run++;
    if ({rdy[0], we_n[0], oe_n[0], rdat[0]} !== {3'b111, last_rd[0]}) begin
      n_fail++;
      $display("FAIL b2b_no_reissue: got rdy=%b we_n=%b oe_n=%b rdata=%h want 1 1 1 %h",
               rdy[0], we_n[0], oe_n[0], rdat[0], last_rd[0]);
    end
  endtask

  task automatic test_wait1();
    int lows; logic [31:0] rd;
    run_req(1, 1'b1, 1'b0, 32'd1064, 32'h0BADC0DE, lows, rd);
    refm[widx(1, 1064)] = 32'h0BADC0DE;
    n_run++;
    if (lows !== 3) begin
      n_fail++; $display("FAIL w1_store_latency: got %0d want 3", lows);
    end
    run_req(1, 1'b0, 1'b1, 32'd1067, 32'h0, lows, rd);
    n_run++;
    if (lows !== 3) begin
      n_fail++; $display("FAIL w1_load_latency: got %0d want 3", lows);
    end
    n_run++;
    if (rd !== ref_rd(1, 1067)) begin
      n_fail++; $display("FAIL w1_low_bits_ignored: got %h want %h", rd, ref_rd(1, 1067));
    end
    last_rd[1] = ref_rd(1, 1067);
    n_run++;
    if ({snap_addr[1], snap_oe[1], snap_addr[2], snap_oe[2]} !== {18'd20, 1'b0, 18'd21, 1'b0}) begin
      n_fail++;
      $display("FAIL w1_load_bus: got %0d/%b %0d/%b want 20/0 21/0",
               snap_addr[1], snap_oe[1], snap_addr[2], snap_oe[2]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    w_en[0] = 1'b1; addr[0] = 32'd1424; wdat[0] = 32'h11112222;
    @(negedge clk); #1;
    n_run++;
    if (we_n[0] !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_setup: got we_n=%b want 0", we_n[0]);
    end
    rst = 1'b1; w_en[0] = 1'b0;
    #1;
    n_run++;
    if ({we_n[0], oe_n[0], rdy[0], sa[0], rdat[0]} !== {3'b111, 18'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL rst_mid: got we_n=%b oe_n=%b rdy=%b addr=%0d rdata=%h want 1 1 1 0 0",
               we_n[0], oe_n[0], rdy[0], sa[0], rdat[0]);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    n_run++;
    if ({we_n[0], oe_n[0], rdy[0]} !== 3'b111) begin
      n_fail++;
      $display("FAIL rst_no_retry: got we_n=%b oe_n=%b rdy=%b want 1 1 1", we_n[0], oe_n[0], rdy[0]);
    end
    last_rd[0] = '0; last_rd[1] = '0;
  endtask

  task automatic test_random(input int s, input int n);
    int lows, want_lows; logic [31:0] rd, a, d, exp; bit is_w;
    want_lows = (s == 0) ? 5 : 3;
    for (int i = 0; i < n; i++) begin
      is_w = 1'($urandom_range(0, 1));
      a = 32'd1024 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
`ifndef SRAM_ADDR_CHECK_EN
      if ($urandom_range(0, 3) == 0) a = a + 32'h80000;
`endif
      d = $urandom;
      run_req(s, is_w, !is_w, a, d, lows, rd);
      n_run++;
      if (lows !== want_lows) begin
        n_fail++; $display("FAIL rand%0d_latency #%0d: got %0d want %0d", s, i, lows, want_lows);
      end
      if (is_w) begin
        refm[widx(s, a)] = d;
        exp = last_rd[s];
      end else begin
        exp = ref_rd(s, a);
        last_rd[s] = exp;
      end
      n_run++;
      if (rd !== exp) begin
        n_fail++;
        $display("FAIL rand%0d_%s #%0d addr=%h: got %h want %h", s, is_w ? "store" : "load", i,
                 a, rd, exp);
      end
    end
  endtask

`ifdef SRAM_ADDR_CHECK_EN
  task automatic test_addr_check();
    int lows; logic [31:0] rd;
    run_req(0, 1'b0, 1'b1, 32'd100, 32'h0, lows, rd);
    n_run++;
    if (lows !== 1 || aerr[0] !== 1'b1 || rd !== last_rd[0]) begin
      n_fail++;
      $display("FAIL addr_check: got lows=%0d err=%b rdata=%h want 1 1 %h", lows, aerr[0], rd,
               last_rd[0]);
    end
    n_run++;
    if ({snap_we[0], snap_oe[0], snap_we[1], snap_oe[1]} !== 4'b1111) begin
      n_fail++;
      $display("FAIL addr_check_bus: got %b want 1111",
               {snap_we[0], snap_oe[0], snap_we[1], snap_oe[1]});
    end
  endtask
`endif

  initial begin
    n_run = 0; n_fail = 0;
    rst = 1'b1; r_en = '0; w_en = '0;
    for (int s = 0; s < 2; s++) begin
      addr[s] = '0; wdat[s] = '0; last_rd[s] = '0;
    end
    for (int i = 0; i < 262144; i++) begin
      mem0[i] = '0; mem1[i] = '0;
    end
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_wait1();
    test_reset_mid();
    test_random(0, 40);
    test_random(1, 20);
`ifdef SRAM_ADDR_CHECK_EN
    test_addr_check();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Memory-side counterpart of the execute stage: accepts the data-memory request produced by EXE/MEM (mem_r_en, mem_w_en, alu_result as address, val_rm as store data).
- Performs it on an external 16-bit asynchronous SRAM as two half-word accesses.
- Drives ready low while busy; the top level uses ~ready as the pipeline freeze.
- Returns a 32-bit load word to the MEM/WB register.

Parameters:
- BASE_ADDR, 1024, data-memory base; subtracted from the address before mapping.
- WAIT_CYCLES, 2, cycles each half-word access is held on the SRAM bus (>=1).
- SRAM_AW, 18, SRAM half-word address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_r_en  in  1  load request; held stable while ready=0.
- mem_w_en  in  1  store request; held stable while ready=0.
- address  in  32  byte address (ALU result).
- wdata  in  32  store data (val_rm).
- rdata  out  32  load result; valid in the cycle ready returns high; held until the next load completes.
- ready  out  1  0 while a request is in progress.
- sram_dq  inout  16  SRAM data bus.
- sram_addr  out  SRAM_AW  SRAM half-word address.
- sram_we_n  out  1  write enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_ce_n, sram_ub_n, sram_lb_n  out  1 each  tied 0 (always enabled, both bytes).

Behaviour:
- Address map: word = (address - BASE_ADDR) >> 2. Low half at {word, 0}, high half at {word, 1}, truncated to SRAM_AW bits. address[1:0] is ignored.
- States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE. State register and wait counter (0..WAIT_CYCLES-1) are reset asynchronously to IDLE/0.
- IDLE:
  - ready = ~(mem_r_en | mem_w_en), combinational.
  - On mem_w_en go to WR_LO; else on mem_r_en go to RD_LO.
  - Both asserted is illegal and is treated as a write.
- WR_LO / WR_HI:
  - sram_addr = low/high half address.
  - sram_dq driven with wdata[15:0] / wdata[31:16].
  - sram_we_n = 0, sram_oe_n = 1.
  - Stay WAIT_CYCLES cycles, then advance WR_LO->WR_HI->DONE.
- RD_LO / RD_HI:
  - sram_addr = low/high half address, sram_we_n = 1, sram_oe_n = 0, sram_dq = Z.
  - In the last wait cycle, sample sram_dq into rdata[15:0] / rdata[31:16].
  - Advance RD_LO->RD_HI->DONE.
- DONE: ready = 1 for exactly one cycle, bus idle, then IDLE. The request still asserted in DONE is not re-issued (the pipeline advances on this edge).
- ready = 0 in all WR/RD states.
- Latency: request seen in IDLE at cycle 0 → ready low for cycles 0..2*WAIT_CYCLES → ready high at cycle 2*WAIT_CYCLES+1 (default: 5 low, high on the 6th).
- Bus idle (IDLE, DONE, reset): sram_we_n = 1, sram_oe_n = 1, sram_dq = Z, sram_addr = 0.
- rdata resets to 0. A store never modifies rdata.
- Reset mid-access: immediate return to IDLE, we_n released. The partially written word is undefined; no retry.
- Back-to-back: a new request can be accepted in the IDLE cycle right after DONE.

Optional Feature:
- Macro SRAM_ADDR_CHECK_EN.
- Defined:
  - In IDLE, a request with address < BASE_ADDR or word >= 2^(SRAM_AW-1) goes directly to DONE without any SRAM access. Latency is 1 cycle of ready=0.
  - A sticky output addr_err (1 bit, reset 0) is set to 1.
  - rdata is unchanged.
- Not defined: no check, the address wraps via truncation, and the addr_err port does not exist.

Test Plan:
- Reset: assert rst mid-WR_LO → same cycle sram_we_n=1, ready=1, rdata=0, sram_dq=Z.
- Store: address=1024, wdata=0xDEADBEEF → sram_addr=0 with dq=0xBEEF for 2 cycles, then sram_addr=1 with dq=0xDEAD for 2 cycles; ready low 5 cycles, high the 6th.
- Load: SRAM model holds [2]=0x5678, [3]=0x1234; address=1028, mem_r_en → rdata=0x12345678 when ready rises; sram_oe_n=0 only during RD states.
- Back-to-back: store 0xCAFEF00D to 1032, then load 1032 the next IDLE cycle → rdata=0xCAFEF00D; no extra access issued in DONE.
- WAIT_CYCLES=1: load → ready low 3 cycles; address[1:0]=3 maps to the same word as address[1:0]=0.
- SRAM_ADDR_CHECK_EN: load from address=100 → ready low 1 cycle, addr_err=1, no SRAM activity, rdata unchanged.
